// File: rtl/aes_spi_frontend_pkg.sv
// rtl/aes_spi_frontend_pkg.sv - shared types and constants for the AES serial front-end
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX    = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        TX    = 3'd4
    } spi_state_t;

    localparam int RESULT_BITS = 128;
    localparam int CHK_BITS    = 8;

    // Serial frame length: message block followed by the key.
    function automatic int frame_bits(input int nb, input int nk);
        return 32 * nb + 32 * nk;
    endfunction

endpackage

// File: rtl/aes_spi_frontend_if.sv
// rtl/aes_spi_frontend_if.sv - serial and core-side signal bundle of the AES front-end
interface aes_spi_frontend_if
    import aes_pkg::*;
#(
    parameter int nb = 4,
    parameter int nk = 4
);
    logic                   cs_enc;
    logic                   Mosi;
    logic                   Miso;
    logic [32*nb-1:0]       core_msg;
    logic [32*nk-1:0]       core_key;
    logic                   core_start;
    logic                   core_done;
    logic [RESULT_BITS-1:0] core_result;
    logic                   frame_err;

    // Front-end view: consumes the serial inputs and core result, drives the rest.
    modport slave (
        input  cs_enc, Mosi, core_done, core_result,
        output Miso, core_msg, core_key, core_start, frame_err
    );

    // SPI master / core view.
    modport master (
        output cs_enc, Mosi, core_done, core_result,
        input  Miso, core_msg, core_key, core_start, frame_err
    );

endinterface

// File: rtl/aes_spi_frontend_shift_reg.sv
// rtl/aes_spi_frontend_shift_reg.sv - MSB-first shift register with parallel load
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_serial_in,
    output logic             o_msb,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    // Parallel load wins over shifting; serial data enters at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift_en) begin
            r_data <= {r_data[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_msb  = r_data[WIDTH-1];
    assign o_data = r_data;

endmodule

// File: rtl/aes_spi_frontend.sv
// rtl/aes_spi_frontend.sv - AES serial front-end (optional TX checksum: AES_SPI_CHECKSUM_EN)
module aes_spi_frontend
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input logic               clk,
    input logic               rst,
    aes_spi_frontend_if.slave bus
);

    localparam int FB = frame_bits(nb, nk);
    localparam int CW = $clog2(FB + 1);

`ifdef AES_SPI_CHECKSUM_EN
    localparam int TXB = RESULT_BITS + CHK_BITS;
`else
    localparam int TXB = RESULT_BITS;
`endif

    // Only AES geometries are meaningful; nr must match the key length.
    if (nb != 4 || !(nk == 4 || nk == 6 || nk == 8) || nr != nk + 6) begin : g_bad_cfg
        $error("aes_spi_frontend: unsupported nb/nk/nr combination");
    end

    spi_state_t         r_state;
    spi_state_t         w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [32*nb-1:0]   r_core_msg;
    logic [32*nk-1:0]   r_core_key;

    logic               w_core_start;
    logic               w_frame_err;
    logic               w_rx_shift;
    logic               w_rx_last;
    logic               w_tx_load;
    logic               w_tx_shift;

    logic [FB-1:0]      w_rx_data;
    logic               w_rx_msb;
    logic [TXB-1:0]     w_tx_data;
    logic               w_tx_msb;
    logic [TXB-1:0]     w_tx_load_data;
    logic               w_unused;

`ifdef AES_SPI_CHECKSUM_EN
    // Trailer byte: XOR of all sixteen result bytes.
    function automatic logic [CHK_BITS-1:0] result_checksum(input logic [RESULT_BITS-1:0] res);
        logic [CHK_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < RESULT_BITS / CHK_BITS; i++) begin
            c = c ^ res[CHK_BITS*i +: CHK_BITS];
        end
        return c;
    endfunction

    assign w_tx_load_data = {bus.core_result, result_checksum(bus.core_result)};
`else
    assign w_tx_load_data = bus.core_result;
`endif

    spi_shift_reg #(.WIDTH(FB)) u_rx_sr (
        .clk         (clk),
        .rst         (rst),
        .i_shift_en  (w_rx_shift),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_serial_in (bus.Mosi),
        .o_msb       (w_rx_msb),
        .o_data      (w_rx_data)
    );

    spi_shift_reg #(.WIDTH(TXB)) u_tx_sr (
        .clk         (clk),
        .rst         (rst),
        .i_shift_en  (w_tx_shift),
        .i_load      (w_tx_load),
        .i_load_data (w_tx_load_data),
        .i_serial_in (1'b0),
        .o_msb       (w_tx_msb),
        .o_data      (w_tx_data)
    );

    // The RX top bit falls off the end and TX is only read serially.
    assign w_unused = ^{w_rx_msb, w_rx_data[FB-1], w_tx_data};

    // State and shared bit counter; reset abandons any core operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_core_start = 1'b0;
        w_frame_err  = 1'b0;
        w_rx_shift   = 1'b0;
        w_rx_last    = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_shift   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.cs_enc) begin
                    w_rx_shift  = 1'b1;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = RX;
                end
            end
            RX: begin
                if (bus.cs_enc) begin
                    w_rx_shift = 1'b1;
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (r_cnt == CW'(FB - 1)) begin
                        w_rx_last   = 1'b1;
                        w_state_nxt = START;
                    end
                end else begin
                    // Chip select dropped mid-frame: discard and flag it.
                    w_frame_err = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                w_core_start = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    w_tx_load   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TX;
                end
            end
            TX: begin
                // A deasserted chip select only stalls the shifter.
                if (bus.cs_enc) begin
                    w_tx_shift = 1'b1;
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (r_cnt == CW'(TXB - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch message and key together with the last frame bit so they are valid while core_start is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_msg <= '0;
            r_core_key <= '0;
        end else if (w_rx_last) begin
            {r_core_msg, r_core_key} <= {w_rx_data[FB-2:0], bus.Mosi};
        end
    end

    assign bus.core_msg   = r_core_msg;
    assign bus.core_key   = r_core_key;
    assign bus.core_start = w_core_start;
    assign bus.frame_err  = w_frame_err;
    assign bus.Miso       = (r_state == TX) & w_tx_msb;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// tb/tb_aes_spi_frontend.sv - directed self-checking bench for aes_spi_frontend
module tb_aes_spi_frontend;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_spi_frontend_if #(.nb(4), .nk(4)) bus ();

    aes_spi_frontend #(.nk(4), .nb(4), .nr(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef AES_SPI_CHECKSUM_EN
    localparam int TXN = 136;
`else
    localparam int TXN = 128;
`endif

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [135:0] rx_acc;

    logic [127:0] fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] fips_msg = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] ones     = {128{1'b1}};
    logic [127:0] m3       = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    logic [127:0] k3       = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    logic [127:0] r3       = 128'h01234567_89abcdef_fedcba98_76543210;
    logic [127:0] m4       = 128'h11111111_22222222_33333333_44444444;
    logic [127:0] k4       = 128'h55555555_66666666_77777777_88888888;
    logic [127:0] r5       = 128'h0102030405060708090a0b0c0d0e0f10;
    logic [127:0] stub_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_bit({tag, "_miso"}, bus.Miso, 1'b0);
        check_vec({tag, "_msg"}, 136'(bus.core_msg), 136'(0));
        check_vec({tag, "_key"}, 136'(bus.core_key), 136'(0));
        check_bit({tag, "_start"}, bus.core_start, 1'b0);
        check_bit({tag, "_err"}, bus.frame_err, 1'b0);
    endtask

    // Expected serial image of a result, including the trailer when enabled.
    function automatic logic [135:0] tx_expect(input logic [127:0] res);
`ifdef AES_SPI_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 16; i++) c = c ^ res[8*i +: 8];
        return {res, c};
`else
        return {8'h00, res};
`endif
    endfunction

    task automatic send_frame(input logic [127:0] msg, input logic [127:0] key);
        logic [255:0] f;
        f = {msg, key};
        for (int i = 0; i < 256; i++) begin
            bus.cs_enc = 1'b1;
            bus.Mosi   = f[255-i];
            if (i == 255) check_bit("start_early", bus.core_start, 1'b0);
            tick();
        end
        bus.cs_enc = 1'b0;
        bus.Mosi   = 1'b0;
    endtask

    task automatic rx_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cs_enc = 1'b1;
            #1;
            rx_acc = {rx_acc[134:0], bus.Miso};
            tick();
        end
        bus.cs_enc = 1'b0;
    endtask

    task automatic core_reply(input logic [127:0] res);
        tick();
        tick();
        bus.core_done   = 1'b1;
        bus.core_result = res;
        tick();
        bus.core_done   = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.cs_enc      = 1'b0;
        bus.Mosi        = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        rx_acc          = '0;
        tick();
        tick();
        rst = 1'b0;
        check_outputs_zero("reset");

        // FIPS-197 vector with the core answered by its known ciphertext.
        send_frame(fips_msg, fips_key);
        check_bit("fips_start", bus.core_start, 1'b1);
        check_vec("fips_msg", 136'(bus.core_msg), 136'(fips_msg));
        check_vec("fips_key", 136'(bus.core_key), 136'(fips_key));
        check_bit("fips_err", bus.frame_err, 1'b0);
        tick();
        check_bit("fips_start_width", bus.core_start, 1'b0);
        core_reply(fips_ct);
        rx_acc = '0;
        rx_bits(TXN);
        check_vec("fips_result", rx_acc, tx_expect(fips_ct));
        check_bit("fips_idle_miso", bus.Miso, 1'b0);

        // Stub core: result = msg ^ key; cs_enc held high during WAIT must be ignored.
        send_frame(ones, 128'h0);
        check_bit("stub_start", bus.core_start, 1'b1);
        check_vec("stub_msg", 136'(bus.core_msg), 136'(ones));
        stub_res   = ones ^ 128'h0;
        bus.cs_enc = 1'b1;
        tick();
        check_bit("stub_start_width", bus.core_start, 1'b0);
        bus.cs_enc = 1'b0;
        core_reply(stub_res);
        check_bit("stub_first_bit", bus.Miso, 1'b1);
        rx_acc = '0;
        rx_bits(TXN);
        check_vec("stub_result", rx_acc, tx_expect({128{1'b1}}));

        // RX abort after 100 bits.
        for (int i = 0; i < 100; i++) begin
            bus.cs_enc = 1'b1;
            bus.Mosi   = i[0];
            tick();
        end
        bus.cs_enc = 1'b0;
        #1;
        check_bit("abort_err", bus.frame_err, 1'b1);
        check_bit("abort_no_start", bus.core_start, 1'b0);
        tick();
        check_bit("abort_err_width", bus.frame_err, 1'b0);
        check_vec("abort_msg_kept", 136'(bus.core_msg), 136'(ones));
        check_vec("abort_key_kept", 136'(bus.core_key), 136'(0));
        tick();
        check_bit("abort_still_no_start", bus.core_start, 1'b0);

        // Full frame after the abort, then a TX stall of 5 cycles.
        send_frame(m3, k3);
        check_bit("post_abort_start", bus.core_start, 1'b1);
        check_vec("post_abort_msg", 136'(bus.core_msg), 136'(m3));
        check_vec("post_abort_key", 136'(bus.core_key), 136'(k3));
        tick();
        core_reply(r3);
        rx_acc = '0;
        rx_bits(64);
        for (int i = 0; i < 5; i++) begin
            check_bit("tx_stall_hold", bus.Miso, r3[63]);
            tick();
        end
        check_bit("tx_stall_no_err", bus.frame_err, 1'b0);
        rx_bits(TXN - 64);
        check_vec("tx_stall_result", rx_acc, tx_expect(r3));
        check_bit("tx3_idle_miso", bus.Miso, 1'b0);

        // Back-to-back frame, then reset while waiting for the core.
        send_frame(m4, k4);
        check_bit("b2b_start", bus.core_start, 1'b1);
        check_vec("b2b_msg", 136'(bus.core_msg), 136'(m4));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("wait_reset");
        bus.core_done   = 1'b1;
        bus.core_result = ones;
        tick();
        bus.core_done = 1'b0;
        check_bit("late_done_miso", bus.Miso, 1'b0);
        check_bit("late_done_start", bus.core_start, 1'b0);
        tick();
        check_bit("late_done_miso2", bus.Miso, 1'b0);

        // Recovery after reset; carries the checksum trailer when enabled.
        send_frame(fips_msg, fips_key);
        check_bit("final_start", bus.core_start, 1'b1);
        tick();
        core_reply(r5);
        rx_acc = '0;
        rx_bits(TXN);
`ifdef AES_SPI_CHECKSUM_EN
        check_vec("chk_trailer", rx_acc, {r5, 8'h10});
`else
        check_vec("final_result", rx_acc, {8'h00, r5});
`endif
        check_bit("final_idle_miso", bus.Miso, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_spi_frontend.md
# aes_spi_frontend

Serial front-end for the AES encryption core. It sits between the SPI master and the cipher datapath. It deserialises a message and key frame from `Mosi`, starts the core with a one-cycle pulse, and captures the 128-bit result. It then shifts the result back to the master on `Miso`.

## Interface
Parameters:
- `nk`, default 4: key length in 32-bit words (4/6/8).
- `nb`, default 4: block length in 32-bit words; fixed at 4 for AES.
- `nr`, default 10: round count; passed through to the core, not used internally.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: sole clock; the serial bit clock is the same clock.
- `rst`, in, 1: synchronous active-high reset.
- `cs_enc`, in, 1: chip select, active-high; frames a transaction.
- `Mosi`, in, 1: serial data from the master, MSB first.
- `Miso`, out, 1: serial result to the master, MSB first.
- `core_msg`, out, 32*nb: deserialised plaintext, stable from `core_start` until the next frame.
- `core_key`, out, 32*nk: deserialised key, stable from `core_start` until the next frame.
- `core_start`, out, 1: one-cycle start pulse to the core.
- `core_done`, in, 1: core result valid, sampled in the WAIT state only.
- `core_result`, in, 128: ciphertext from the core.
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, RX, START, WAIT, TX.
- **IDLE**
  - `Miso`=0 and the bit counter is 0.
  - When `cs_enc`=1, the `Mosi` bit of that cycle is shifted in; go to RX.
- **RX**
  - Each cycle with `cs_enc`=1, shift `Mosi` into a (32*nb+32*nk)-bit register.
  - Frame order: message bits 127..0 first, then key bits 32*nk-1..0.
  - The counter is `$clog2(32*nb+32*nk+1)` bits wide.
  - On the last bit, go to START.
- **RX abort**
  - `cs_enc`=0 in RX before the last bit aborts the frame.
  - Assert `frame_err` for one cycle, clear the counter, go to IDLE.
  - `core_msg` and `core_key` keep their previous values.
- **START**
  - Load `core_msg` and `core_key` from the shift register.
  - `core_start`=1 for exactly this cycle; go to WAIT.
- **WAIT**
  - `cs_enc` is ignored.
  - On `core_done`=1, capture `core_result` into the TX shift register and go to TX.
  - `core_done` in any other state is ignored.
- **TX**
  - `Miso` is the MSB of the TX register.
  - Each cycle with `cs_enc`=1 shifts left by one and increments the TX counter.
  - `cs_enc`=0 holds the state; there is no abort in TX.
  - After 128 shifts (136 when the checksum is enabled) go to IDLE with `Miso`=0.
- **Reset**
  - `rst` in any state returns to IDLE on the next edge.
  - All outputs are 0 after reset: `Miso`, `core_msg`, `core_key`, `core_start`, `frame_err`.
  - A core operation already in flight is abandoned; its `core_done` is ignored.

## Timing
- RX: the first bit is sampled on the first edge with `cs_enc`=1 in IDLE. The frame length is 32*nb+32*nk edges: 256 for nk=4, 320 for nk=6, 384 for nk=8.
- `core_start` is high in the cycle after the edge that sampled the last frame bit.
- WAIT → TX: `Miso` carries `core_result[127]` in the cycle after `core_done` is sampled.
- TX: bit k is presented for at least one cycle and advances only on edges with `cs_enc`=1.
- Back-to-back frames: a new RX can begin in the first IDLE cycle after TX completes.
- Minimum overhead beyond the core latency is 2 cycles: START plus the capture edge.

## Configuration
- Macro: `AES_SPI_CHECKSUM_EN`.
- When defined:
  - TX appends an 8-bit trailer after the 128 result bits: the XOR of the sixteen result bytes, sent MSB first.
  - The TX length is 136 bits.
- When undefined:
  - TX is exactly 128 bits.
  - No checksum logic is present.

## Structure
- Shared package `aes_pkg`:
  - `spi_state_t` enum (IDLE, RX, START, WAIT, TX).
  - `RESULT_BITS`=128.
  - `CHK_BITS`=8.
  - `frame_bits(nb,nk)` function.
- One sub-module, `spi_shift_reg`:
  - Parameterised width, shift enable, parallel load, serial in, MSB out.
  - Instantiated once for RX and once for TX.

## Test plan
- **FIPS-197 vector**, real core, nk=4: key 000102030405060708090a0b0c0d0e0f, message 00112233445566778899aabbccddeeff → `Miso` returns 69c4e0d86a7b0430d8cdb78070b4c55a, `frame_err`=0.
- **Stub core** (result = msg ^ key, `core_done` 3 cycles after `core_start`), message all-ones, key 0 → `core_start` is exactly one cycle wide, 257 cycles after the first sampled bit. The returned result is ffff…ff.
- **RX abort:** drop `cs_enc` after 100 bits → `frame_err` pulses once, state returns to IDLE, and `core_start` never asserts. The following full frame completes correctly.
- **TX stall:** toggle `cs_enc` low for 5 cycles mid-TX → `Miso` holds its bit and the full 128-bit result is intact.
- **Reset in WAIT:** assert `rst` before `core_done` → all outputs are 0 and a late `core_done` is ignored.
- **With `AES_SPI_CHECKSUM_EN`,** result 0102…10 → trailer 0x10, 136 bits total.
